// File: rtl/modn_updown_counter_if.sv
// Control and status bundle for the modulo-N up/down counter.
interface modn_updown_counter_if #(
  parameter int WIDTH = 4
);
  logic             enable;
  logic             load;
  logic             mode;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;
  logic             load_err;

  modport master (
    output enable, load, mode, din,
    input  count, tc, wrap, load_err
  );

  modport slave (
    input  enable, load, mode, din,
    output count, tc, wrap, load_err
  );
endinterface

// File: rtl/modn_updown_counter.sv
// Loadable modulo-N up/down counter with wrap/saturate, load range check and
// a combinational terminal-count output for cascading digits.
module modn_updown_counter #(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 12,
  parameter int RESET_VAL = 0,
  parameter int SATURATE  = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  modn_updown_counter_if.slave  bus
);

  if (MODULUS < 2 || MODULUS > (1 << WIDTH) || RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_param
    $error("modn_updown_counter: illegal MODULUS or RESET_VAL");
  end

  localparam logic [WIDTH:0]   MOD_W  = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]   MOD_M1 = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_C  = WIDTH'(RESET_VAL);
  localparam logic             SAT    = (SATURATE != 0);

  logic [WIDTH-1:0] count_p0;
  logic             wrap_p0;
  logic             load_err_p0;
  logic             at_max;
  logic             at_min;
  logic             din_ok;

  // Terminal handling is decided from the extended result, never from a
  // natural WIDTH-bit overflow, so MODULUS = 2^WIDTH behaves like any other.
  function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH:0] c);
    logic [WIDTH:0] s;
    s = c + 1'b1;
    if (s == MOD_W) s = SAT ? c : '0;
    return s[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] step_down(input logic [WIDTH:0] c);
    logic [WIDTH:0] s;
    s = c - 1'b1;
    if (s[WIDTH]) s = SAT ? c : MOD_M1;
    return s[WIDTH-1:0];
  endfunction

  assign at_max = ({1'b0, count_p0} == MOD_M1);
  assign at_min = (count_p0 == '0);
  assign din_ok = ({1'b0, bus.din} < MOD_W);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_p0    <= RST_C;
      wrap_p0     <= 1'b0;
      load_err_p0 <= 1'b0;
    end else if (bus.load) begin
      wrap_p0 <= 1'b0;
      if (din_ok) begin
        count_p0    <= bus.din;
        load_err_p0 <= 1'b0;
      end else begin
        load_err_p0 <= 1'b1;
      end
    end else if (bus.enable) begin
      load_err_p0 <= 1'b0;
      if (bus.mode) begin
        count_p0 <= step_up({1'b0, count_p0});
        wrap_p0  <= at_max & ~SAT;
      end else begin
        count_p0 <= step_down({1'b0, count_p0});
        wrap_p0  <= at_min & ~SAT;
      end
    end else begin
      wrap_p0     <= 1'b0;
      load_err_p0 <= 1'b0;
    end
  end

  assign bus.count    = count_p0;
  assign bus.wrap     = wrap_p0;
  assign bus.load_err = load_err_p0;
  assign bus.tc       = ~reset & bus.enable &
                        ((bus.mode & at_max) | (~bus.mode & at_min));

endmodule

// File: doc/modn_updown_counter.md
Name: modn_updown_counter

Overview:
- Parametrised, loadable modulo-N up/down counter. Generalises the fixed mod-12 counter to any width and modulus.
- Adds count enable, selectable wrap or saturate, load range checking, and terminal-count/wrap outputs.
- The `tc` output lets several instances be chained into multi-digit counters: stage k+1 `enable` is driven from stage k `tc`.

Parameters:
- WIDTH, 4, counter and din width in bits.
- MODULUS, 12, number of states; count range is 0..MODULUS-1. Legal range 2 <= MODULUS <= 2^WIDTH.
- RESET_VAL, 0, count value on reset. Must be < MODULUS.
- SATURATE, 0: 0 = wrap at the terminal value; 1 = hold at the terminal value.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  count enable; when low, no count step occurs.
- load  input  1  synchronous parallel load request.
- mode  input  1  direction: 1 = up, 0 = down. Sampled every cycle.
- din  input  WIDTH  load value.
- count  output  WIDTH  registered counter value.
- tc  output  1  combinational terminal count, for cascading.
- wrap  output  1  registered one-cycle pulse on a wrap event.
- load_err  output  1  registered one-cycle pulse on a rejected load.

Behaviour:
- Reset (asynchronous, active-high):
  - While reset is high: count = RESET_VAL, wrap = 0, load_err = 0, regardless of clock.
  - The first clock edge after reset deasserts operates normally.
- Priority at each rising clock edge: load > enable > hold.
- Load, when load = 1:
  - If din < MODULUS: count <= din, load_err <= 0.
  - Otherwise: count unchanged, load_err <= 1.
  - Load applies whether enable is 0 or 1, and suppresses any count step in that cycle.
  - wrap <= 0 in any load cycle.
- Count step, when load = 0 and enable = 1:
  - Up (mode = 1):
    - count == MODULUS-1 and SATURATE = 0: count <= 0, wrap <= 1.
    - count == MODULUS-1 and SATURATE = 1: count holds, wrap <= 0.
    - Otherwise: count <= count+1.
  - Down (mode = 0):
    - count == 0 and SATURATE = 0: count <= MODULUS-1, wrap <= 1.
    - count == 0 and SATURATE = 1: count holds, wrap <= 0.
    - Otherwise: count <= count-1.
- Hold, when load = 0 and enable = 0: count holds, wrap <= 0, load_err <= 0.
- Pulse outputs: wrap and load_err are high for exactly one cycle per event and clear on the next edge unless the event repeats.
- tc = enable & ((mode & count == MODULUS-1) | (~mode & count == 0)).
  - Purely combinational; no register delay.
  - Asserted in saturate mode as well.
  - Forced 0 while reset is high. Count is RESET_VAL then, so tc follows the formula once reset releases.
- Arithmetic:
  - Incrementing and decrementing are done in WIDTH+1 bits internally.
  - count never leaves 0..MODULUS-1 by any input sequence, including MODULUS = 2^WIDTH, where wrap must not depend on natural overflow.
- Direction change: mode may toggle on any cycle. The step direction uses the mode value at that edge, with no extra latency.
- Simultaneous load and terminal condition: load wins; wrap <= 0.
- Reset mid-operation: pending wrap and load_err pulses are cleared immediately.
- Elaboration checks: illegal MODULUS or RESET_VAL must produce an elaboration error (generate-time $error).

Test Plan:
- Defaults, reset high for 2 cycles, then enable = 1, mode = 1 for 14 cycles:
  - count goes 0, 1, ..., 11, 0, 1.
  - wrap is high for one cycle after the 11 -> 0 step.
  - tc is high only while count = 11.
- Defaults, load din = 5 with enable = 0, then enable = 1, mode = 0 for 7 cycles:
  - count goes 5, 4, 3, 2, 1, 0, 11, 10.
  - wrap pulses once after the 0 -> 11 step.
- Load din = 12 while count = 3, then load din = 15:
  - count stays 3.
  - load_err is high for each of those two cycles and 0 on the following cycle.
- SATURATE = 1, up-counting from 9 for 5 cycles:
  - count goes 10, 11, 11, 11, 11.
  - wrap never asserts.
  - tc is high while count = 11 and enable = 1.
- WIDTH = 4, MODULUS = 16, RESET_VAL = 7, asserting reset asynchronously between edges while counting at count = 15:
  - count = 7 immediately, with no clock edge.
  - wrap = 0 and load_err = 0.
  - After release, up-count from 7 wraps 15 -> 0 correctly.
- Two cascaded instances (MODULUS = 10), stage-1 enable = stage-0 tc, count up for 105 cycles:
  - Decimal pair reads 0,5 (tens = 0, units = 5).
  - Stage 1 advances only on edges where stage 0 shows 9.
